// File: rtl/seq_mult_unsigned_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the legal operand-width range.
package seq_mult_unsigned_pkg;

    // Control states of the multiplier.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Legal range for the operand width N.
    localparam int N_MIN = 2;
    localparam int N_MAX = 32;

endpackage

// File: rtl/seq_mult_unsigned_rca_n.sv
// Parametrised N-bit ripple-carry adder built from a chain of full-adder
// cells, plus the full-adder cell itself.

// Single-bit full adder.
module fa (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// N-bit ripple-carry adder: carry ripples from bit 0 to bit N-1.
module rca_n #(
    parameter int N = 4
) (
    output logic [N-1:0] Sum,
    output logic         Cout,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin
);

    logic [N:0] w_carry;

    assign w_carry[0] = Cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        fa u_fa (
            .s  (Sum[i]),
            .co (w_carry[i+1]),
            .a  (A[i]),
            .b  (B[i]),
            .ci (w_carry[i])
        );
    end

    assign Cout = w_carry[N];

endmodule

// File: rtl/seq_mult_unsigned.sv
// Iterative shift-and-add unsigned multiplier. One N-bit ripple-carry adder
// is reused over N RUN cycles; the result is announced with a one-cycle done
// pulse and held in the product register until the next result.
module seq_mult_unsigned
    import seq_mult_unsigned_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    // Refuse to elaborate with an operand width outside the supported range.
    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("seq_mult_unsigned: N=%0d outside legal range %0d..%0d", N, N_MIN, N_MAX);
    end

    state_t          r_state;
    state_t          w_next_state;
    logic [N-1:0]    r_mcand;
    logic [N-1:0]    r_acc_hi;
    logic [N-1:0]    r_acc_lo;
    logic [CW-1:0]   r_count;
    logic [2*N-1:0]  r_product;

    logic [N-1:0]    w_addend;
    logic [N-1:0]    w_sum;
    logic            w_cout;
    logic [2*N-1:0]  w_shifted;
    logic            w_last;

    // Add the multiplicand only when the current multiplier bit is set.
    assign w_addend = r_acc_lo[0] ? r_mcand : '0;

    rca_n #(
        .N (N)
    ) u_rca (
        .Sum  (w_sum),
        .Cout (w_cout),
        .A    (r_acc_hi),
        .B    (w_addend),
        .Cin  (1'b0)
    );

    // Right shift of the (2N+1)-bit {cout, sum, acc_lo}; the carry becomes
    // the top bit, so nothing is lost.
    assign w_shifted = {w_cout, w_sum, r_acc_lo[N-1:1]};
    assign w_last    = (r_count == CW'(N - 1));
    assign product   = r_product;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs, decoded from the current state.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, shift-and-add iteration and result latch.
    // NOTE: every datapath register is reset, since a mid-operation abort must
    // also clear the visible product, not only the control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_acc_hi <= '0;
                        r_acc_lo <= b;
                        r_count  <= '0;
                    end
                end
                RUN: begin
                    {r_acc_hi, r_acc_lo} <= w_shifted;
                    r_count              <= r_count + CW'(1);
                    if (w_last) begin
                        r_product <= w_shifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
